// File: rtl/regfile_wb_sched.sv
// Regfile writeback arbiter (pipe vs MDU) and destination scoreboard.
// Generates the RAW/WAW issue stall and drives the single write port.
module regfile_wb_sched #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int STARVE_MAX = 4,
  localparam int IW = $clog2(NREG),
  localparam int SW = $clog2(STARVE_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic            issue_unit,
  input  logic            issue_rd_we,
  input  logic [IW-1:0]   issue_rd_s,
  input  logic [IW-1:0]   issue_rs1_s,
  input  logic [IW-1:0]   issue_rs2_s,
  output logic            issue_stall,
  input  logic            flush,
  input  logic            pipe_wb_valid,
  input  logic [IW-1:0]   pipe_wb_rd_s,
  input  logic [XLEN-1:0] pipe_wb_rd_v,
  output logic            pipe_wb_ready,
  input  logic            mdu_wb_valid,
  input  logic [IW-1:0]   mdu_wb_rd_s,
  input  logic [XLEN-1:0] mdu_wb_rd_v,
  output logic            mdu_wb_ready,
  output logic            regf_we,
  output logic [IW-1:0]   rd_s,
  output logic [XLEN-1:0] rd_v,
  output logic [NREG-1:0] busy_vec
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] owner;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] owner_nxt;
  logic [SW-1:0]   starve;
  logic            wb_src;
  logic            starved;
  logic            pipe_gnt;
  logic            mdu_gnt;
  logic            accept;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_busy;

  assign busy_vec = busy;

  always_comb begin
    rs1_busy = (issue_rs1_s != '0) && busy[issue_rs1_s];
    rs2_busy = (issue_rs2_s != '0) && busy[issue_rs2_s];
    rd_busy  = (issue_rd_s != '0) && busy[issue_rd_s];
    issue_stall = issue_valid &&
                  (rs1_busy || rs2_busy || (issue_rd_we && rd_busy));
  end

  assign accept = issue_valid && !issue_stall && !flush;

  // MDU is forced through once it has lost STARVE_MAX times in a row
  assign starved  = (starve == SW'(STARVE_MAX));
  assign mdu_gnt  = mdu_wb_valid && (!pipe_wb_valid || starved);
  assign pipe_gnt = pipe_wb_valid && !mdu_gnt;

  assign pipe_wb_ready = pipe_gnt && rst_n;
  assign mdu_wb_ready  = mdu_gnt && rst_n;

  always_comb begin
    busy_nxt  = busy;
    owner_nxt = owner;
    if (regf_we && (owner[rd_s] == wb_src))
      busy_nxt[rd_s] = 1'b0;
    if (flush)
      busy_nxt = busy_nxt & owner;
    if (accept && issue_rd_we && (issue_rd_s != '0)) begin
      busy_nxt[issue_rd_s]  = 1'b1;
      owner_nxt[issue_rd_s] = issue_unit;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= '0;
      owner <= '0;
    end else begin
      busy  <= busy_nxt;
      owner <= owner_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (mdu_gnt || !mdu_wb_valid) begin
      starve <= '0;
    end else if (!starved) begin
      starve <= starve + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regf_we <= 1'b0;
      rd_s    <= '0;
      rd_v    <= '0;
      wb_src  <= 1'b0;
    end else begin
      regf_we <= 1'b0;
      unique case (1'b1)
        mdu_gnt: begin
          regf_we <= (mdu_wb_rd_s != '0);
          rd_s    <= mdu_wb_rd_s;
          rd_v    <= mdu_wb_rd_v;
          wb_src  <= 1'b1;
        end
        pipe_gnt: begin
          regf_we <= (pipe_wb_rd_s != '0);
          rd_s    <= pipe_wb_rd_s;
          rd_v    <= pipe_wb_rd_v;
          wb_src  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched.
// Hand-computed expectations for hazards, arbitration, flush and reset.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_unit;
  logic        issue_rd_we;
  logic [4:0]  issue_rd_s;
  logic [4:0]  issue_rs1_s;
  logic [4:0]  issue_rs2_s;
  logic        issue_stall;
  logic        flush;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd_s;
  logic [31:0] pipe_wb_rd_v;
  logic        pipe_wb_ready;
  logic        mdu_wb_valid;
  logic [4:0]  mdu_wb_rd_s;
  logic [31:0] mdu_wb_rd_v;
  logic        mdu_wb_ready;
  logic        regf_we;
  logic [4:0]  rd_s;
  logic [31:0] rd_v;
  logic [31:0] busy_vec;

  int total = 0;
  int bad = 0;

  regfile_wb_sched dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_unit(issue_unit),
    .issue_rd_we(issue_rd_we), .issue_rd_s(issue_rd_s),
    .issue_rs1_s(issue_rs1_s), .issue_rs2_s(issue_rs2_s),
    .issue_stall(issue_stall), .flush(flush),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd_s(pipe_wb_rd_s),
    .pipe_wb_rd_v(pipe_wb_rd_v), .pipe_wb_ready(pipe_wb_ready),
    .mdu_wb_valid(mdu_wb_valid), .mdu_wb_rd_s(mdu_wb_rd_s),
    .mdu_wb_rd_v(mdu_wb_rd_v), .mdu_wb_ready(mdu_wb_ready),
    .regf_we(regf_we), .rd_s(rd_s), .rd_v(rd_v),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic unit, input logic we,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    issue_valid = 1'b1;
    issue_unit  = unit;
    issue_rd_we = we;
    issue_rd_s  = rd;
    issue_rs1_s = rs1;
    issue_rs2_s = rs2;
  endtask

  initial begin
    rst_n = 1'b0;
    issue_valid = 0; issue_unit = 0; issue_rd_we = 0;
    issue_rd_s = 0; issue_rs1_s = 0; issue_rs2_s = 0;
    flush = 0;
    pipe_wb_valid = 1; pipe_wb_rd_s = 5'd1; pipe_wb_rd_v = 32'h1;
    mdu_wb_valid = 1; mdu_wb_rd_s = 5'd2; mdu_wb_rd_v = 32'h2;
    #12;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_we", {31'b0, regf_we}, 32'h0);
    chk("rst_rd_s", {27'b0, rd_s}, 32'h0);
    chk("rst_rd_v", rd_v, 32'h0);
    chk("rst_pready", {31'b0, pipe_wb_ready}, 32'h0);
    chk("rst_mready", {31'b0, mdu_wb_ready}, 32'h0);
    pipe_wb_valid = 0; mdu_wb_valid = 0;
    #10 rst_n = 1'b1;
    step();

    // RAW on x5 through pipe writeback
    issue(1'b0, 1'b1, 5'd5, 5'd0, 5'd0);
    #1 chk("t1_nostall", {31'b0, issue_stall}, 32'h0);
    step();
    issue(1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
    #1 chk("t1_raw_stall", {31'b0, issue_stall}, 32'h1);
    chk("t1_busy5", {31'b0, busy_vec[5]}, 32'h1);
    issue_valid = 0;
    pipe_wb_valid = 1; pipe_wb_rd_s = 5'd5; pipe_wb_rd_v = 32'hDEADBEEF;
    #1 chk("t1_pready", {31'b0, pipe_wb_ready}, 32'h1);
    step();
    pipe_wb_valid = 0;
    chk("t1_we", {31'b0, regf_we}, 32'h1);
    chk("t1_rd_s", {27'b0, rd_s}, 32'd5);
    chk("t1_rd_v", rd_v, 32'hDEADBEEF);
    chk("t1_busy_hold", {31'b0, busy_vec[5]}, 32'h1);
    step();
    chk("t1_busy_clr", {31'b0, busy_vec[5]}, 32'h0);
    chk("t1_we_drop", {31'b0, regf_we}, 32'h0);
    issue(1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
    #1 chk("t1_stall_drop", {31'b0, issue_stall}, 32'h0);
    issue_valid = 0;
    step();

    // starvation: pipe x4, MDU forced, then pipe again
    pipe_wb_valid = 1; pipe_wb_rd_s = 5'd1; pipe_wb_rd_v = 32'h11;
    mdu_wb_valid = 1; mdu_wb_rd_s = 5'd2; mdu_wb_rd_v = 32'h22;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("t2_pready_c%0d", i), {31'b0, pipe_wb_ready},
          (i == 4) ? 32'h0 : 32'h1);
      chk($sformatf("t2_mready_c%0d", i), {31'b0, mdu_wb_ready},
          (i == 4) ? 32'h1 : 32'h0);
      step();
      if (i == 4) begin
        chk("t2_mdu_rd_s", {27'b0, rd_s}, 32'd2);
        chk("t2_mdu_rd_v", rd_v, 32'h22);
      end
    end
    pipe_wb_valid = 0; mdu_wb_valid = 0;
    step();

    // flush keeps MDU-owned, drops pipe-owned, blocks same-cycle issue
    issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    step();
    issue_valid = 0; flush = 1;
    step();
    flush = 0;
    chk("t3_mdu_kept", {31'b0, busy_vec[7]}, 32'h1);
    issue(1'b0, 1'b1, 5'd8, 5'd0, 5'd0);
    step();
    chk("t3_busy8_set", {31'b0, busy_vec[8]}, 32'h1);
    issue(1'b0, 1'b1, 5'd9, 5'd0, 5'd0);
    flush = 1;
    step();
    flush = 0; issue_valid = 0;
    chk("t3_flush_vec", busy_vec, 32'h0000_0080);

    // writeback to x0
    pipe_wb_valid = 1; pipe_wb_rd_s = 5'd0; pipe_wb_rd_v = 32'h1234;
    #1 chk("t4_x0_ready", {31'b0, pipe_wb_ready}, 32'h1);
    step();
    pipe_wb_valid = 0;
    chk("t4_x0_we", {31'b0, regf_we}, 32'h0);
    chk("t4_x0_rd_v", rd_v, 32'h1234);
    step();
    chk("t4_x0_busy", busy_vec, 32'h0000_0080);

    // WAW on x3 held until its writeback commits
    issue(1'b0, 1'b1, 5'd3, 5'd0, 5'd0);
    step();
    #1 chk("t5_waw_stall", {31'b0, issue_stall}, 32'h1);
    pipe_wb_valid = 1; pipe_wb_rd_s = 5'd3; pipe_wb_rd_v = 32'h33;
    step();
    pipe_wb_valid = 0;
    chk("t5_stall_we", {31'b0, issue_stall}, 32'h1);
    step();
    chk("t5_stall_drop", {31'b0, issue_stall}, 32'h0);
    step();
    issue_valid = 0;
    chk("t5_reissue", busy_vec, 32'h0000_0088);

    // mismatched owner leaves busy; matching owner clears
    mdu_wb_valid = 1; mdu_wb_rd_s = 5'd3; mdu_wb_rd_v = 32'h44;
    step();
    mdu_wb_rd_s = 5'd7;
    step();
    mdu_wb_valid = 0;
    chk("t6_mismatch", busy_vec, 32'h0000_0088);
    step();
    chk("t6_match_clr", busy_vec, 32'h0000_0008);

    // async reset mid-cycle with write pending
    pipe_wb_valid = 1; pipe_wb_rd_s = 5'd4; pipe_wb_rd_v = 32'h55;
    step();
    chk("t7_pre_we", {31'b0, regf_we}, 32'h1);
    chk("t7_pre_busy", busy_vec, 32'h0000_0008);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_busy", busy_vec, 32'h0);
    chk("t7_async_we", {31'b0, regf_we}, 32'h0);
    chk("t7_async_ready", {31'b0, pipe_wb_ready}, 32'h0);
    pipe_wb_valid = 0;
    #10 rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
